servo_pwm: RTL and testbench

//  Consumes the servo command stream produced by servo_controller (16-bit
//  stb/ack word stream) and drives N_SERVOS hobby-servo PWM pins. Each word

---
 rtl/servo_pwm.sv | 103 ++++++++++
 tb/tb_servo_pwm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm.sv
// Servo PWM generator: accepts channel/width command words and drives N_SERVOS
// hobby-servo pins, with widths double-buffered so updates land only on frame boundaries.
module servo_pwm #(
    parameter int N_SERVOS  = 8,
    parameter int TICK_DIV  = 50,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int CENTER_US = 1500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         input_servos,
    input  logic                input_servos_stb,
    output logic                input_servos_ack,
    output logic [N_SERVOS-1:0] pwm,
    output logic                frame_start
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int US_W  = $clog2(PERIOD_US);

    logic [PRE_W-1:0]    prescaler;
    logic [US_W-1:0]     us_count;
    logic [US_W-1:0]     us_next;
    logic                tick;
    logic                boundary;
    logic                xfer;
    logic [3:0]          ch;
    logic [11:0]         w_clamped;
    logic [11:0]         shadow      [N_SERVOS];
    logic [11:0]         active      [N_SERVOS];
    logic [11:0]         active_next [N_SERVOS];
    logic [N_SERVOS-1:0] pwm_next;

    function automatic logic [11:0] clamp_width(input logic [11:0] raw);
        if (raw == 12'd0)
            return 12'd0;
        else if (raw < 12'(MIN_US))
            return 12'(MIN_US);
        else if (raw > 12'(MAX_US))
            return 12'(MAX_US);
        else
            return raw;
    endfunction

    assign tick      = (prescaler == PRE_W'(TICK_DIV - 1));
    assign boundary  = tick && (us_count == US_W'(PERIOD_US - 1));
    assign xfer      = input_servos_stb && input_servos_ack;
    assign ch        = input_servos[15:12];
    assign w_clamped = clamp_width(input_servos[11:0]);

    always_comb begin
        us_next = us_count;
        if (boundary)
            us_next = '0;
        else if (tick)
            us_next = us_count + 1'b1;
    end

    // pwm is computed from next-state counters so the pin rises on the frame_start cycle
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < N_SERVOS; i++) begin
            active_next[i] = boundary ? shadow[i] : active[i];
            pwm_next[i]    = (32'(us_next) < 32'(active_next[i]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler        <= '0;
            us_count         <= '0;
            frame_start      <= 1'b0;
            input_servos_ack <= 1'b0;
        end else begin
            prescaler        <= tick ? '0 : prescaler + 1'b1;
            us_count         <= us_next;
            frame_start      <= boundary;
            // Dropping ack for one cycle after each accept limits the rate to one word per two cycles
            input_servos_ack <= !xfer;
        end
    end

    // Channel numbers at or above N_SERVOS match no slot, so such words are silently dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SERVOS; i++) begin
                shadow[i] <= 12'(CENTER_US);
                active[i] <= 12'(CENTER_US);
            end
            pwm <= '0;
        end else begin
            for (int i = 0; i < N_SERVOS; i++) begin
                if (xfer && (ch == 4'(i)))
                    shadow[i] <= w_clamped;
                active[i] <= active_next[i];
            end
            pwm <= pwm_next;
        end
    end

endmodule

// File: tb/tb_servo_pwm.sv
// Self-checking bench for servo_pwm: a time-based reference model checked every cycle,
// plus per-frame pulse-width measurements against hand-computed widths.
module tb_servo_pwm;

    localparam int N     = 8;
    localparam int TD    = 2;
    localparam int P     = 3000;
    localparam int MINW  = 500;
    localparam int MAXW  = 2500;
    localparam int CEN   = 1500;
    localparam int FRAME = TD * P;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic [15:0]  word = 16'h0000;
    logic         stb  = 1'b0;
    logic         ack;
    logic [N-1:0] pwm;
    logic         fs;

    servo_pwm #(
        .N_SERVOS (N),
        .TICK_DIV (TD),
        .PERIOD_US(P),
        .MIN_US   (MINW),
        .MAX_US   (MAXW),
        .CENTER_US(CEN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .input_servos    (word),
        .input_servos_stb(stb),
        .input_servos_ack(ack),
        .pwm             (pwm),
        .frame_start     (fs)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs and reset as seen by the most recent rising edge
    logic        stb_q  = 1'b0;
    logic        rst_q  = 1'b0;
    logic        ack_q  = 1'b0;
    logic [15:0] word_q = 16'h0000;
    int          edge_k = 0;

    always @(posedge clk) begin
        stb_q  <= stb;
        word_q <= word;
        rst_q  <= rst;
        ack_q  <= ack;
        edge_k <= rst ? edge_k + 1 : 0;
    end

    function automatic int clampw(input int w);
        if (w == 0)    return 0;
        if (w < MINW)  return MINW;
        if (w > MAXW)  return MAXW;
        return w;
    endfunction

    // Reference model: position in the frame follows directly from edges since reset release
    int   k_m;
    logic ack_m;
    int   shadow_m [N];
    int   active_m [N];

    initial begin
        logic         xfer_m;
        logic         bnd;
        logic [N-1:0] exp_pwm;
        int           us;
        int           chn;
        forever begin
            @(negedge clk);
            if (!rst) begin
                k_m   = 0;
                ack_m = 1'b0;
                for (int i = 0; i < N; i++) begin
                    shadow_m[i] = CEN;
                    active_m[i] = CEN;
                end
                check("reset_pwm", 32'(pwm), 0);
                check("reset_fs", 32'(fs), 0);
                check("reset_ack", 32'(ack), 0);
            end else if (!rst_q) begin
                check("release_pwm", 32'(pwm), 0);
                check("release_fs", 32'(fs), 0);
                check("release_ack", 32'(ack), 0);
            end else begin
                k_m++;
                bnd = ((k_m % FRAME) == 0);
                if (bnd)
                    for (int i = 0; i < N; i++) active_m[i] = shadow_m[i];
                xfer_m = stb_q && ack_m;
                ack_m  = !xfer_m;
                chn    = int'(word_q[15:12]);
                if (xfer_m && chn < N)
                    shadow_m[chn] = clampw(int'(word_q[11:0]));
                us = (k_m / TD) % P;
                for (int i = 0; i < N; i++) exp_pwm[i] = (us < active_m[i]);
                check("model_pwm", 32'(pwm), 32'(exp_pwm));
                check("model_fs", 32'(fs), 32'(bnd));
                check("model_ack", 32'(ack), 32'(ack_m));
            end
        end
    end

    // High-cycle count per channel for each frame, framed by frame_start
    int cnt [0:15][0:N-1];
    int fidx = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst && fs === 1'b1 && fidx < 15) begin
                fidx++;
                for (int i = 0; i < N; i++) cnt[fidx][i] = 0;
            end
            for (int i = 0; i < N; i++)
                if (pwm[i] === 1'b1) cnt[fidx][i]++;
        end
    end

    task automatic goto(input int t);
        int n;
        n = 0;
        while (edge_k < t && n < 70000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (edge_k < t)
            check("goto_timeout", 32'(edge_k), 32'(t));
    endtask

    task automatic send(input logic [15:0] wv);
        int n;
        word = wv;
        stb  = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        while (ack_q !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        stb = 1'b0;
        check("xfer_accepted", 32'(ack_q), 1);
        check("ack_low_after_xfer", 32'(ack), 0);
        @(posedge clk);
        #1;
        check("ack_high_again", 32'(ack), 1);
    endtask

    logic [15:0] burst [10];
    int          ew [1:8][0:N-1];
    int          nx;

    initial begin
        burst = '{16'h3258, 16'h38AE, 16'h42BC, 16'h38AE, 16'h5320,
                  16'h38AE, 16'h6384, 16'h38AE, 16'h73E8, 16'h38AE};
        ew[1] = '{3000, 3000, 3000, 3000, 3000, 3000, 3000, 3000};
        ew[2] = '{2048, 3000, 3000, 3000, 3000, 3000, 3000, 3000};
        ew[3] = '{2048, 1000, 3000, 3000, 3000, 3000, 3000, 3000};
        ew[4] = '{2048, 5000,    0, 3000, 3000, 3000, 3000, 3000};
        ew[5] = '{2048, 5000,    0, 1200, 1400, 3000, 3000, 3000};
        ew[6] = '{2048, 5000,    0, 1200, 1400, 1600, 1800, 2000};
        ew[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
        ew[8] = '{3000, 3000, 3000, 3000, 3000, 3000, 3000, 3000};

        repeat (3) @(posedge clk);
        #1;
        check("in_reset_pwm", 32'(pwm), 0);
        check("in_reset_ack", 32'(ack), 0);
        rst = 1'b1;
        check("ack_before_first_edge", 32'(ack), 0);
        @(posedge clk);
        #1;
        check("ack_first_edge", 32'(ack), 1);

        goto(7000);
        send(16'h0400);
        goto(13000);
        send(16'h1064);
        goto(19000);
        send(16'h1FFF);
        goto(19100);
        send(16'h2000);
        goto(19200);
        send(16'h95DC);

        // Burst straddles the edge-30000 frame boundary; the third accept lands on it
        goto(29995);
        nx = 0;
        for (int j = 0; j < 10; j++) begin
            word = burst[j];
            stb  = 1'b1;
            @(posedge clk);
            #1;
            if (ack_q === 1'b1) nx++;
        end
        stb = 1'b0;
        check("burst_xfers", 32'(nx), 5);

        goto(42500);
        check("pwm0_high_before_rst", 32'(pwm[0]), 1);
        rst = 1'b0;
        #1;
        check("rst_async_pwm", 32'(pwm), 0);
        check("rst_async_ack", 32'(ack), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_after_rerelease", 32'(ack), 1);
        goto(12010);

        check("frame_count", 32'(fidx), 9);
        for (int f = 1; f <= 8; f++)
            if (f != 7)
                for (int c = 0; c < N; c++)
                    check($sformatf("width_f%0d_ch%0d", f, c), 32'(cnt[f][c]), 32'(ew[f][c]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
